pattern_buffer_bank: RTL

//  Real storage for the PAT pattern buffer: NUM_BUFS buffers x NUM_FIELDS fields x D_WIDTH bits.

---
 rtl/patbuf_pkg.sv | 33 +++
 rtl/patbuf_load_fsm.sv | 93 +++++++++
 rtl/pattern_buffer_bank.sv | 125 ++++++++++++
 3 files changed

// File: rtl/patbuf_pkg.sv
// patbuf_pkg
//   Shared sizing, address types and loader state encoding for the PAT
//   pattern buffer bank (pattern_buffer_bank and patbuf_load_fsm).
//   Storage geometry: NUM_BUFS buffers x NUM_FIELDS fields x D_WIDTH bits.
//   A storage address is {buffer index, field index}, buffer in the MSBs.
package patbuf_pkg;

  localparam int D_WIDTH      = 8;
  localparam int BUFP_WIDTH   = 3;
  localparam int FIELDP_WIDTH = 5;
  localparam int ADR_WIDTH    = BUFP_WIDTH + FIELDP_WIDTH;
  localparam int NUM_BUFS     = 1 << BUFP_WIDTH;
  localparam int NUM_FIELDS   = 1 << FIELDP_WIDTH;
  localparam int NUM_WORDS    = NUM_BUFS * NUM_FIELDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } patbuf_load_state_t;

  typedef logic [BUFP_WIDTH-1:0]   buf_idx_t;
  typedef logic [FIELDP_WIDTH-1:0] field_idx_t;
  typedef logic [ADR_WIDTH-1:0]    buf_field_adr_t;

  localparam field_idx_t LAST_FIELD = field_idx_t'(NUM_FIELDS - 1);

  // Build a storage address from its buffer and field parts.
  function automatic buf_field_adr_t make_adr(input buf_idx_t b, input field_idx_t f);
    return {b, f};
  endfunction

endpackage

// File: rtl/patbuf_load_fsm.sv
// patbuf_load_fsm
//   Host-side streaming loader for one pattern buffer. After an accepted
//   load_start it accepts NUM_FIELDS words (field 0 first) and emits one
//   storage write per accepted word, then pulses load_done for one cycle.
//
//   Handshake: a word transfers on a rising clk edge where load_valid and
//   load_ready are both 1. load_ready is 1 exactly while in LOAD; the host
//   may hold load_valid for any number of cycles and may drop it freely.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   load_start      begin a load (accepted only in IDLE)
//   load_buf        target buffer, latched on accepted start
//   load_valid      host word valid
//   load_ready      registered: loader accepts a word this cycle
//   load_busy       registered: state != IDLE
//   load_done       registered: one-cycle pulse after the last word
//   start_accept    load_start was accepted this cycle
//   ld_wr_en        storage write strobe for the current word
//   ld_wr_adr       storage address {lbuf, cnt} for that write
//   lbuf            latched target buffer
//   state           current state, exposed for debug/checkers
module patbuf_load_fsm
  import patbuf_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [BUFP_WIDTH-1:0]   load_buf,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    start_accept,
  output logic                    ld_wr_en,
  output logic [ADR_WIDTH-1:0]    ld_wr_adr,
  output logic [BUFP_WIDTH-1:0]   lbuf,
  output patbuf_load_state_t      state
);

  field_idx_t cnt;

  assign start_accept = (state == IDLE) && load_start;
  assign ld_wr_en     = (state == LOAD) && load_valid;
  assign ld_wr_adr    = make_adr(lbuf, cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lbuf       <= '0;
      load_ready <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            lbuf       <= load_buf;
            cnt        <= '0;
            load_ready <= 1'b1;
            load_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            // The counter stops on the last field instead of wrapping.
            if (cnt == LAST_FIELD) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          load_done <= 1'b0;
          load_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b0;
          load_busy  <= 1'b0;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pattern_buffer_bank.sv
// pattern_buffer_bank
//   Storage for the PAT pattern buffer: NUM_BUFS x NUM_FIELDS words of
//   D_WIDTH bits, with a PAT read port, a PAT write port and a background
//   streaming loader (patbuf_load_fsm) that owns a second write port.
//
//   While the loader is busy, PAT writes to the buffer being loaded are
//   dropped and wr_collision is set (sticky until an accepted load_start or
//   reset). PAT writes to other buffers proceed alongside loader writes.
//
//   Optional feature macro: PATBUF_RDBYPASS_EN. When defined, a write
//   happening this cycle to the read address is forwarded to field_out in
//   the same cycle; otherwise field_out shows stored contents only.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset (clears storage)
//   buf_fieldp        PAT read address {bufp, fieldp}
//   field_out         PAT read data (combinational)
//   buf_fieldwp       PAT write address {bufp, fieldwp}
//   field_write_en    PAT write strobe
//   field_in          PAT write data
//   load_start        host: begin loading load_buf
//   load_buf          host: target buffer
//   load_valid        host: load_data valid
//   load_data         host: next field word, field 0 first
//   load_ready        loader accepts a word this cycle
//   load_busy         loader in LOAD or DONE
//   load_done         one-cycle pulse after the last word is written
//   wr_collision      sticky: a PAT write was dropped due to a load
module pattern_buffer_bank
  import patbuf_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADR_WIDTH-1:0]    buf_fieldp,
  output logic [D_WIDTH-1:0]      field_out,
  input  logic [ADR_WIDTH-1:0]    buf_fieldwp,
  input  logic                    field_write_en,
  input  logic [D_WIDTH-1:0]      field_in,
  input  logic                    load_start,
  input  logic [BUFP_WIDTH-1:0]   load_buf,
  input  logic                    load_valid,
  input  logic [D_WIDTH-1:0]      load_data,
  output logic                    load_ready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    wr_collision
);

  logic [D_WIDTH-1:0] mem [NUM_WORDS];

  logic               start_accept;
  logic               ld_wr_en;
  logic [ADR_WIDTH-1:0] ld_wr_adr;
  logic [BUFP_WIDTH-1:0] lbuf;
  patbuf_load_state_t ld_state;

  logic               ld_active;
  logic               pat_drop;
  logic               pat_wr_ok;

  patbuf_load_fsm u_load_fsm (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_buf     (load_buf),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .start_accept (start_accept),
    .ld_wr_en     (ld_wr_en),
    .ld_wr_adr    (ld_wr_adr),
    .lbuf         (lbuf),
    .state        (ld_state)
  );

  // Protection covers DONE as well as LOAD: the buffer is not released
  // until the loader is back in IDLE.
  assign ld_active = (ld_state != IDLE);
  assign pat_drop  = field_write_en && ld_active &&
                     (buf_fieldwp[ADR_WIDTH-1 -: BUFP_WIDTH] == lbuf);
  assign pat_wr_ok = field_write_en && !pat_drop;

  // Two write ports. A dropped PAT write can never alias the loader address,
  // so the two writes never target the same word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pat_wr_ok) begin
        mem[buf_fieldwp] <= field_in;
      end
      if (ld_wr_en) begin
        mem[ld_wr_adr] <= load_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_collision <= 1'b0;
    end else if (start_accept) begin
      wr_collision <= 1'b0;
    end else if (pat_drop) begin
      wr_collision <= 1'b1;
    end
  end

`ifdef PATBUF_RDBYPASS_EN
  always_comb begin
    field_out = mem[buf_fieldp];
    if (pat_wr_ok && (buf_fieldwp == buf_fieldp)) begin
      field_out = field_in;
    end
    if (ld_wr_en && (ld_wr_adr == buf_fieldp)) begin
      field_out = load_data;
    end
  end
`else
  assign field_out = mem[buf_fieldp];
`endif

endmodule
